// File: rtl/ro_pkg.sv
`default_nettype none
// ============================================================================
// Module : ro_pkg
// Brief  : Shared FSM state encoding and default settle time for ro_meter_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
package ro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } ro_state_t;

  localparam int c_SETTLE_CYCLES_DEFAULT = 16;

endpackage
`default_nettype wire

// File: rtl/ro_edge_sync.sv
`default_nettype none
// ============================================================================
// Module : ro_edge_sync
// Brief  : Two-flop synchronizer followed by a single-cycle rising-edge detector.
// Rev    : 1.0  initial release
// ============================================================================
module ro_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= async_in;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign rise_pulse = r_sync & ~r_sync_d;

endmodule
`default_nettype wire

// File: rtl/ro_meter_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ro_meter_ctrl
// Brief  : Ring-oscillator frequency meter: settle, gate-window edge count,
//          saturating result. Optional serial readout under RO_METER_SHIFT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module ro_meter_ctrl
  import ro_pkg::*;
#(
  parameter int GATE_W        = 16,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = c_SETTLE_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic              ro_ena,
  input  logic              ro_div_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
`ifdef RO_METER_SHIFT_EN
  ,
  input  logic              shift,
  output logic              sdo
`endif
);

  localparam int                 c_SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   c_CNT_MAX  = {CNT_W{1'b1}};

  ro_state_t           r_state;
  logic [c_SET_W-1:0]  r_settle_cnt;
  logic [GATE_W-1:0]   r_gate_cnt;
  logic [GATE_W-1:0]   r_gate_len;
  logic [CNT_W-1:0]    r_count;
  logic                r_overflow;
  logic                r_ro_ena;
  logic                r_busy;
  logic                r_done;
  logic                w_rise;

  ro_edge_sync u_edge_sync (
    .clk        (clk),
    .reset      (reset),
    .async_in   (ro_div_in),
    .rise_pulse (w_rise)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_gate_cnt   <= '0;
      r_gate_len   <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_ro_ena     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state      <= ST_SETTLE;
            r_gate_len   <= gate_len;
            r_settle_cnt <= '0;
            r_gate_cnt   <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_ro_ena     <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
          end
`ifdef RO_METER_SHIFT_EN
          else if ((r_state == ST_DONE) && shift) begin
            r_count <= r_count << 1;
          end
`endif
        end

        ST_SETTLE: begin
          if (r_settle_cnt == c_SET_LAST) begin
            // A zero-length gate goes straight to DONE with the cleared count.
            if (r_gate_len == '0) begin
              r_state  <= ST_DONE;
              r_ro_ena <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_state  <= ST_MEASURE;
            end
          end else begin
            r_settle_cnt <= r_settle_cnt + c_SET_W'(1);
          end
        end

        ST_MEASURE: begin
          if (w_rise) begin
            if (r_count == c_CNT_MAX) begin
              r_overflow <= 1'b1;
            end else begin
              r_count <= r_count + CNT_W'(1);
            end
          end
          if (r_gate_cnt == r_gate_len - GATE_W'(1)) begin
            r_state  <= ST_DONE;
            r_ro_ena <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_gate_cnt <= r_gate_cnt + GATE_W'(1);
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_ro_ena <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  assign ro_ena   = r_ro_ena;
  assign busy     = r_busy;
  assign done     = r_done;
  assign count    = r_count;
  assign overflow = r_overflow;

`ifdef RO_METER_SHIFT_EN
  assign sdo = r_count[CNT_W-1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_ro_meter_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ro_meter_ctrl
// Brief  : Self-checking bench for ro_meter_ctrl (16-bit and 4-bit count builds).
// Rev    : 1.0  initial release
// ============================================================================
module tb_ro_meter_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] gate_len;
  logic        ro_div_in;

  logic        ro_ena,  busy,  done,  overflow;
  logic [15:0] count;
  logic        ro_ena4, busy4, done4, overflow4;
  logic [3:0]  count4;
`ifdef RO_METER_SHIFT_EN
  logic        shift;
  logic        sdo, sdo4;
`endif

  int checks   = 0;
  int failures = 0;

  // Waveform of ro_div_in as seen at every rising clk edge, indexed by edge number.
  bit hist [0:32767];
  int edge_n = 0;

  int mode   = 0;
  int period = 4;
  int ph     = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    hist[edge_n] <= ro_div_in;
    edge_n       <= edge_n + 1;
  end

  ro_meter_ctrl #(.GATE_W(16), .CNT_W(16), .SETTLE_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .gate_len(gate_len),
    .ro_ena(ro_ena), .ro_div_in(ro_div_in), .busy(busy), .done(done),
    .count(count), .overflow(overflow)
`ifdef RO_METER_SHIFT_EN
    , .shift(shift), .sdo(sdo)
`endif
  );

  ro_meter_ctrl #(.GATE_W(16), .CNT_W(4), .SETTLE_CYCLES(16)) dut4 (
    .clk(clk), .reset(reset), .start(start), .gate_len(gate_len),
    .ro_ena(ro_ena4), .ro_div_in(ro_div_in), .busy(busy4), .done(done4),
    .count(count4), .overflow(overflow4)
`ifdef RO_METER_SHIFT_EN
    , .shift(shift), .sdo(sdo4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    case (mode)
      1: begin
        ph++;
        if (ph >= period) begin
          ph = 0;
          ro_div_in = ~ro_div_in;
        end
      end
      2: ro_div_in = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  // Rising edges the meter must count: an edge visible at clk edge j-2 (low at j-3)
  // is counted at edge j, for every j whose preceding state is MEASURE.
  function automatic int raw_edges(input int s0, input int g);
    int r = 0;
    for (int j = s0 + 17; j <= s0 + 16 + g; j++)
      if (hist[j-2] && !hist[j-3]) r++;
    return r;
  endfunction

  task automatic run_meas(input int g, input bit noisy,
                          output int busy_n, output int ena_n, output int s0);
    busy_n = 0;
    ena_n  = 0;
    start    = 1'b1;
    gate_len = 16'(g);
    s0 = edge_n;
    tick();
    start    = 1'b0;
    gate_len = 16'($urandom);
    check("start_busy", busy, 1);
    check("start_clr_cnt", count, 0);
    check("start_done_lo", done, 0);
    for (int k = 0; k < 4000; k++) begin
      if (done) break;
      if (busy) busy_n++;
      if (ro_ena) ena_n++;
      start = noisy && (k % 7 == 3);
      tick();
    end
    start = 1'b0;
  endtask

  int last_exp;

  task automatic verify(input string tag, input int g, input int s0);
    int raw;
    raw = raw_edges(s0, g);
    check({tag, "_done"}, done, 1);
    check({tag, "_done4"}, done4, 1);
    check({tag, "_cnt"}, count, (raw > 65535) ? 65535 : raw);
    check({tag, "_ovf"}, overflow, (raw > 65535) ? 1 : 0);
    check({tag, "_cnt4"}, count4, (raw > 15) ? 15 : raw);
    check({tag, "_ovf4"}, overflow4, (raw > 15) ? 1 : 0);
    last_exp = (raw > 65535) ? 65535 : raw;
  endtask

  initial begin
    int bn, en, s0, g;
    reset     = 1'b1;
    start     = 1'b0;
    gate_len  = '0;
    ro_div_in = 1'b0;
`ifdef RO_METER_SHIFT_EN
    shift     = 1'b0;
`endif
    repeat (3) tick();
    check("rst_ena", ro_ena, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", count, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;
    repeat (5) tick();

    // Nominal window: 80 cycles of a period-8 input.
    mode = 1; period = 4; ph = 0;
    run_meas(80, 1'b0, bn, en, s0);
    check("nom_busy_cycles", bn, 96);
    verify("nom", 80, s0);
    check("nom_cnt_abs", count, 10);
    repeat (20) tick();
    check("hold_cnt", count, last_exp);
    check("hold_done", done, 1);

    // Zero gate skips MEASURE.
    run_meas(0, 1'b0, bn, en, s0);
    check("zero_ena_cycles", en, 16);
    check("zero_busy_cycles", bn, 16);
    verify("zero", 0, s0);
    check("zero_cnt_abs", count, 0);

    // Saturation of the 4-bit instance.
    period = 2; ph = 0;
    run_meas(200, 1'b0, bn, en, s0);
    verify("sat", 200, s0);
    check("sat_cnt4_abs", count4, 15);
    check("sat_ovf4_abs", overflow4, 1);

    // Reset mid-MEASURE aborts everything.
    start = 1'b1; gate_len = 16'd50;
    tick();
    start = 1'b0;
    repeat (26) tick();
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("abort_ena", ro_ena, 0);
    check("abort_busy", busy, 0);
    check("abort_cnt", count, 0);
    check("abort_cnt4", count4, 0);
    tick();
    reset = 1'b0;
    period = 3; ph = 0;
    repeat (20) tick();
    check("idle_toggle_cnt", count, 0);
    check("idle_toggle_done", done, 0);
    run_meas(30, 1'b0, bn, en, s0);
    check("post_rst_busy_cycles", bn, 46);
    verify("post_rst", 30, s0);

    // Start pulses while busy must not restart or stretch the measurement.
    period = 5; ph = 0;
    run_meas(40, 1'b1, bn, en, s0);
    check("noisy_busy_cycles", bn, 56);
    verify("noisy", 40, s0);

    // Randomised windows and input waveforms.
    for (int it = 0; it < 6; it++) begin
      mode   = $urandom_range(1, 2);
      period = $urandom_range(1, 6);
      ph     = 0;
      g      = $urandom_range(1, 60);
      repeat ($urandom_range(4, 12)) tick();
      run_meas(g, 1'(it & 1), bn, en, s0);
      check($sformatf("rnd%0d_busy_cycles", it), bn, 16 + g);
      verify($sformatf("rnd%0d", it), g, s0);
    end

`ifdef RO_METER_SHIFT_EN
    mode = 0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("sdo_bit%0d", i), sdo, (last_exp >> (15 - i)) & 1);
      shift = 1'b1;
      tick();
    end
    shift = 1'b0;
    check("shift_cnt_zero", count, 0);
    check("shift_cnt4_zero", count4, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
